// File: rtl/pwm_desde_pid_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_desde_pid_pkg
//  Purpose  : Shared widths, default parameters and the duty clamp classifier
//  Revision : 1.0 - initial release
// ============================================================================
package pwm_desde_pid_pkg;

    localparam int c_pwmin_w     = 18;
    localparam int c_cnt_w_def   = 10;
    localparam int c_shift_def   = 8;
    localparam int c_presc_def   = 1;

    typedef enum logic [1:0] {
        SAT_NONE = 2'b00,
        SAT_BAJO = 2'b01,
        SAT_ALTO = 2'b10
    } sat_e;

    // Classifies an already-shifted sample against the [0, 2^cnt_w) duty range.
    function automatic sat_e clamp_class(input logic signed [c_pwmin_w-1:0] v,
                                         input int cnt_w);
        logic signed [31:0] ext;
        ext = 32'(v);
        if (ext < 0)
            return SAT_BAJO;
        else if (ext >= (32'sd1 <<< cnt_w))
            return SAT_ALTO;
        return SAT_NONE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_desde_pid_saturador.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_saturador
//  Purpose  : Combinational arithmetic shift and clamp of the PID result
//  Revision : 1.0 - initial release
// ============================================================================
module pwm_saturador
    import pwm_desde_pid_pkg::*;
#(
    parameter int CNT_W = c_cnt_w_def,
    parameter int SHIFT = c_shift_def
) (
    input  logic signed [c_pwmin_w-1:0] pwmin,
    output logic        [CNT_W:0]       duty,
    output logic                        sat_alto,
    output logic                        sat_bajo
);

    logic signed [c_pwmin_w-1:0] w_v;
    sat_e                        w_cls;

    assign w_v   = pwmin >>> SHIFT;
    assign w_cls = clamp_class(w_v, CNT_W);

    always_comb begin
        duty     = w_v[CNT_W:0];
        sat_alto = 1'b0;
        sat_bajo = 1'b0;
        case (w_cls)
            SAT_BAJO: begin
                duty     = '0;
                sat_bajo = 1'b1;
            end
            SAT_ALTO: begin
                duty     = {1'b1, {CNT_W{1'b0}}};
                sat_alto = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/pwm_desde_pid.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_desde_pid
//  Purpose  : Double-buffered fixed-period PWM driven by the signed PID output
//  Revision : 1.0 - initial release
// ============================================================================
module pwm_desde_pid
    import pwm_desde_pid_pkg::*;
#(
    parameter int CNT_W = c_cnt_w_def,
    parameter int SHIFT = c_shift_def,
    parameter int PRESC = c_presc_def
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic signed [c_pwmin_w-1:0] PWMin,
    input  logic                        nuevo,
    output logic                        pwm_out,
    output logic                        listo,
    output logic                        sat_alto,
    output logic                        sat_bajo
);

    localparam int                   c_presc_w    = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam logic [c_presc_w-1:0] c_presc_last = c_presc_w'(PRESC - 1);

    logic [c_presc_w-1:0] r_presc;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W:0]       r_shadow;
    logic [CNT_W:0]       r_active;
    logic [CNT_W:0]       w_duty;
    logic                 w_sat_alto;
    logic                 w_sat_bajo;
    logic                 w_tick;
    logic                 w_wrap;

    pwm_saturador #(
        .CNT_W (CNT_W),
        .SHIFT (SHIFT)
    ) u_saturador (
        .pwmin    (PWMin),
        .duty     (w_duty),
        .sat_alto (w_sat_alto),
        .sat_bajo (w_sat_bajo)
    );

    assign w_tick = (r_presc == c_presc_last);
    assign w_wrap = w_tick && (r_cnt == {CNT_W{1'b1}});

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_presc <= '0;
            r_cnt   <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
            r_cnt   <= r_cnt + 1'b1;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // A sample arriving on the wrap edge bypasses the shadow so it governs
    // the period that starts right there.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_shadow <= '0;
            r_active <= '0;
            sat_alto <= 1'b0;
            sat_bajo <= 1'b0;
        end else begin
            if (nuevo) begin
                r_shadow <= w_duty;
                sat_alto <= w_sat_alto;
                sat_bajo <= w_sat_bajo;
            end
            if (w_wrap)
                r_active <= nuevo ? w_duty : r_shadow;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pwm_out <= 1'b0;
            listo   <= 1'b0;
        end else begin
            pwm_out <= ({1'b0, r_cnt} < r_active);
            listo   <= w_wrap;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pwm_desde_pid.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pwm_desde_pid
//  Purpose  : Directed self-checking bench, CNT_W=8 SHIFT=4 PRESC=1
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_desde_pid;

    logic               clk;
    logic               rst;
    logic signed [17:0] PWMin;
    logic               nuevo;
    logic               pwm_out;
    logic               listo;
    logic               sat_alto;
    logic               sat_bajo;

    int n_tests = 0;
    int n_fail  = 0;

    pwm_desde_pid #(
        .CNT_W (8),
        .SHIFT (4),
        .PRESC (1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .PWMin    (PWMin),
        .nuevo    (nuevo),
        .pwm_out  (pwm_out),
        .listo    (listo),
        .sat_alto (sat_alto),
        .sat_bajo (sat_bajo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Waits for listo, then samples the 256 pin cycles of the period that
    // follows, optionally strobing nuevo at loop indices ia / ib.
    task automatic measure(input string tag,
                           input int ia, input logic [17:0] va,
                           input int ib, input logic [17:0] vb,
                           output int highs, output int first_low);
        int guard;
        int listo_cnt;
        guard     = 0;
        listo_cnt = 0;
        highs     = 0;
        first_low = 256;
        while (!listo && guard < 600) begin
            step;
            guard++;
        end
        check({tag, "_listo_seen"}, int'(listo), 1);
        for (int i = 0; i < 256; i++) begin
            if (i == ia) begin
                PWMin = va;
                nuevo = 1'b1;
            end else if (i == ib) begin
                PWMin = vb;
                nuevo = 1'b1;
            end else begin
                nuevo = 1'b0;
            end
            step;
            if (pwm_out) highs++;
            else if (first_low == 256) first_low = i;
            if (listo) listo_cnt++;
        end
        nuevo = 1'b0;
        check({tag, "_listo_once_at_end"}, listo_cnt * 2 + int'(listo), 3);
    endtask

    initial begin
        int n;
        int anyhigh;
        int hi;
        int fl;

        rst   = 1'b0;
        nuevo = 1'b0;
        PWMin = '0;
        repeat (3) step;
        check("rst_pwm_out",  int'(pwm_out),  0);
        check("rst_listo",    int'(listo),    0);
        check("rst_sat_alto", int'(sat_alto), 0);
        check("rst_sat_bajo", int'(sat_bajo), 0);

        // Release with no samples: idle low output, listo every 256 cycles.
        rst     = 1'b1;
        n       = 0;
        anyhigh = 0;
        while (n < 400) begin
            step;
            n++;
            if (pwm_out) anyhigh = 1;
            if (listo) break;
        end
        check("first_listo_delay", n, 256);
        step;
        check("listo_width", int'(listo), 0);
        n = 1;
        while (n < 400 && !listo) begin
            step;
            n++;
            if (pwm_out) anyhigh = 1;
        end
        check("listo_period", n, 256);
        check("idle_pwm_low", anyhigh, 0);
        check("idle_flags", int'({sat_alto, sat_bajo}), 0);

        // Mid-period 128: current period untouched, next one 128 high.
        measure("v128_cur", 50, 18'h00800, -1, '0, hi, fl);
        check("v128_cur_highs", hi, 0);
        check("v128_flags", int'({sat_alto, sat_bajo}), 0);
        measure("v128_next", -1, '0, -1, '0, hi, fl);
        check("v128_next_highs", hi, 128);
        check("v128_next_first_low", fl, 128);

        // Negative sample clamps to 0.
        measure("neg_cur", 10, 18'h3FFFF, -1, '0, hi, fl);
        check("neg_cur_highs", hi, 128);
        check("neg_sat_bajo", int'(sat_bajo), 1);
        check("neg_sat_alto", int'(sat_alto), 0);
        measure("neg_next", -1, '0, -1, '0, hi, fl);
        check("neg_next_highs", hi, 0);
        measure("neg_next2", -1, '0, -1, '0, hi, fl);
        check("neg_next2_highs", hi, 0);

        // Overrange sample clamps to always-high.
        measure("hi_cur", 10, 18'h01000, -1, '0, hi, fl);
        check("hi_cur_highs", hi, 0);
        check("hi_sat_alto", int'(sat_alto), 1);
        check("hi_sat_bajo", int'(sat_bajo), 0);
        measure("hi_next", -1, '0, -1, '0, hi, fl);
        check("hi_next_highs", hi, 256);
        check("hi_across_wrap", int'(pwm_out), 1);
        measure("hi_next2", -1, '0, -1, '0, hi, fl);
        check("hi_next2_highs", hi, 256);

        // Shadow 128, then 64 on the wrap cycle: 64 bypasses straight in.
        measure("byp_cur", 100, 18'h00800, 255, 18'h00400, hi, fl);
        check("byp_cur_highs", hi, 256);
        check("byp_flags", int'({sat_alto, sat_bajo}), 0);
        measure("byp_next", -1, '0, -1, '0, hi, fl);
        check("byp_next_highs", hi, 64);
        measure("byp_next2", -1, '0, -1, '0, hi, fl);
        check("byp_next2_highs", hi, 64);

        // Two samples in a period: the last one wins.
        measure("two_cur", 20, 18'h000A0, 120, 18'h00C80, hi, fl);
        check("two_cur_highs", hi, 64);
        measure("two_next", -1, '0, -1, '0, hi, fl);
        check("two_next_highs", hi, 200);
        check("two_next_first_low", fl, 200);

        // Reset in the middle of a 128-duty period.
        measure("pre_rst", 10, 18'h00800, -1, '0, hi, fl);
        check("pre_rst_highs", hi, 200);
        for (int i = 0; i < 50; i++) begin
            if (i == 20) begin
                PWMin = 18'h3FFFF;
                nuevo = 1'b1;
            end else begin
                nuevo = 1'b0;
            end
            step;
        end
        nuevo = 1'b0;
        check("mid_pwm_high", int'(pwm_out), 1);
        check("mid_sat_bajo", int'(sat_bajo), 1);
        rst = 1'b0;
        step;
        check("mid_rst_pwm_out",  int'(pwm_out),  0);
        check("mid_rst_listo",    int'(listo),    0);
        check("mid_rst_sat_bajo", int'(sat_bajo), 0);
        check("mid_rst_sat_alto", int'(sat_alto), 0);
        rst     = 1'b1;
        n       = 0;
        anyhigh = 0;
        while (n < 400) begin
            step;
            n++;
            if (pwm_out) anyhigh = 1;
            if (listo) break;
        end
        check("post_rst_listo_delay", n, 256);
        check("post_rst_pwm_low", anyhigh, 0);
        measure("post_rst", -1, '0, -1, '0, hi, fl);
        check("post_rst_highs", hi, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pwm_desde_pid.md
# pwm_desde_pid

Consumer end of the controller's 18-bit `PWMin` output: accepts the signed PID result on a one-cycle strobe, scales and clamps it to a duty value, and drives a fixed-period PWM pin. New duty values are double-buffered and only applied at period boundaries, so the output never glitches. A period-start pulse tells the stage sequencer when to launch the next PID computation.

## Interface
- `CNT_W`, 10: period counter width; period = 2^CNT_W ticks.
- `SHIFT`, 8: arithmetic right shift applied to `PWMin` before clamping.
- `PRESC`, 1: clk cycles per counter tick (≥1).
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset; one clock, reset is synchronous and active-low.
- `PWMin`  in  18  signed two's-complement PID result.
- `nuevo`  in  1  one-cycle strobe: `PWMin` valid this cycle.
- `pwm_out`  out  1  PWM pin, registered.
- `listo`  out  1  one-cycle pulse at each period start (request next sample).
- `sat_alto`  out  1  last captured sample clamped to 100 %.
- `sat_bajo`  out  1  last captured sample was negative, clamped to 0 %.

## Operation
- Clamp: `v = PWMin >>> SHIFT` (signed). `v < 0` → duty 0, `sat_bajo`=1. `v ≥ 2^CNT_W` → duty 2^CNT_W (always high), `sat_alto`=1. Otherwise duty = v, both flags 0. Duty register is CNT_W+1 bits.
- Capture: on `nuevo`, clamped duty → shadow register; flags updated the same edge; they hold until the next `nuevo`.
- Prescaler counts 0..PRESC-1; tick asserted when it reaches PRESC-1, then wraps to 0. PRESC=1 → tick every cycle.
- Period counter increments on tick, wraps 2^CNT_W-1 → 0 naturally.
- Wrap event = tick while counter = 2^CNT_W-1. On wrap: active duty ← shadow; `listo` pulses the next cycle (aligned with counter = 0).
- `nuevo` coinciding with wrap: clamped incoming value loads into both shadow and active (bypass); the old shadow is discarded.
- Multiple `nuevo` within one period: last one wins.
- `pwm_out` ← (counter < active duty). Duty 0 → constant low; duty 2^CNT_W → constant high, no gap at wrap.
- No state machine beyond the counters; `listo` is the only handshake output, and `nuevo` carries no backpressure: it is always accepted.

## Timing
- Reset (`rst`=0 at an edge): prescaler, counter, shadow, active duty = 0; `pwm_out`, `listo`, `sat_alto`, `sat_bajo` = 0. Reset mid-period aborts it immediately; the first `listo` comes after a full 2^CNT_W·PRESC cycles.
- `pwm_out` is registered: it reflects the comparison for the counter value of the previous cycle, with one-cycle latency from counter to pin.
- Capture latency: `nuevo` at edge N → shadow and flags valid after edge N.
- Application: duty changes on `pwm_out` starting in the first period after the next wrap. In the bypass case, it starts in the period beginning at that wrap.
- `listo` period = 2^CNT_W·PRESC clk cycles, width exactly 1 cycle.

## Structure
- Shared package holds the `PWMin` width (18), default `CNT_W`/`SHIFT`/`PRESC`, and a clamp function.
- One sub-module: `pwm_saturador`, a combinational shift + clamp producing duty[CNT_W:0], `sat_alto` and `sat_bajo`. The top holds the prescaler, counter, shadow/active registers and output flops.

## Test plan
Test parameters: CNT_W=8, SHIFT=4, PRESC=1 (period 256 cycles).
- Reset held, then released with no `nuevo` → `pwm_out`=0 throughout, flags 0, `listo` every 256 cycles, first pulse 256 cycles after release.
- `nuevo` with `PWMin`=0x00800 (v=128) mid-period → current period unchanged; the following period has exactly 128 high cycles then 128 low; flags 0.
- `PWMin`=0x3FFFF (−1) → `sat_bajo`=1, `pwm_out` low for whole periods. `PWMin`=0x01000 (v=256) → `sat_alto`=1, `pwm_out` high continuously across wraps.
- `nuevo` on the wrap cycle with v=64 while shadow holds 128 → the period starting at that wrap has 64 high cycles; 128 is never applied.
- Two `nuevo` in one period (v=10 then v=200) → next period has 200 high cycles.
- `rst` asserted mid-period with duty 128 active → next cycle `pwm_out`=0, all registers 0, counter restarts at 0.
